// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types for the GRF write-port arbiter: register/data widths, FSM states, FIFO entry layout.
package grf_arb_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FORCE
    } state_t;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] pc;
    } entry_t;

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle around the GRF write-port arbiter: pipeline write, auxiliary producer, read-hazard and GRF sides.
interface grf_wb_arbiter_if;

    logic                                pipe_we_i;
    logic [grf_arb_pkg::REG_AW-1:0]      pipe_waddr_i;
    logic [grf_arb_pkg::DATA_W-1:0]      pipe_wdata_i;
    logic [grf_arb_pkg::DATA_W-1:0]      pipe_pc_i;
    logic                                aux_valid_i;
    logic                                aux_ready_o;
    logic [grf_arb_pkg::REG_AW-1:0]      aux_waddr_i;
    logic [grf_arb_pkg::DATA_W-1:0]      aux_wdata_i;
    logic [grf_arb_pkg::DATA_W-1:0]      aux_pc_i;
    logic [grf_arb_pkg::REG_AW-1:0]      rd_addr1_i;
    logic [grf_arb_pkg::REG_AW-1:0]      rd_addr2_i;
    logic                                rd_pend1_o;
    logic                                rd_pend2_o;
    logic                                pipe_stall_o;
    logic                                grf_we_o;
    logic [grf_arb_pkg::REG_AW-1:0]      grf_waddr_o;
    logic [grf_arb_pkg::DATA_W-1:0]      grf_wdata_o;
    logic [grf_arb_pkg::DATA_W-1:0]      grf_pc_o;

    modport slave (
        input  pipe_we_i, pipe_waddr_i, pipe_wdata_i, pipe_pc_i,
        input  aux_valid_i, aux_waddr_i, aux_wdata_i, aux_pc_i,
        input  rd_addr1_i, rd_addr2_i,
        output aux_ready_o, rd_pend1_o, rd_pend2_o, pipe_stall_o,
        output grf_we_o, grf_waddr_o, grf_wdata_o, grf_pc_o
    );

    modport master (
        output pipe_we_i, pipe_waddr_i, pipe_wdata_i, pipe_pc_i,
        output aux_valid_i, aux_waddr_i, aux_wdata_i, aux_pc_i,
        output rd_addr1_i, rd_addr2_i,
        input  aux_ready_o, rd_pend1_o, rd_pend2_o, pipe_stall_o,
        input  grf_we_o, grf_waddr_o, grf_wdata_o, grf_pc_o
    );

endinterface

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO of auxiliary GRF writes; exposes per-slot address/valid for the pending compare.
module wb_fifo
    import grf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  entry_t                       din,
    output entry_t                       head,
    output logic                         full,
    output logic                         empty,
    output logic [CW-1:0]                count,
    output logic [DEPTH-1:0][REG_AW-1:0] addrs,
    output logic [DEPTH-1:0]             valids
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Slot valid bits are tracked directly so reset discards every queued entry at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valids <= '0;
        end else begin
            if (push) begin
                wr_ptr         <= wr_ptr + PW'(1);
                valids[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + PW'(1);
                valids[rd_ptr] <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) addrs[i] = mem[i].waddr;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: W-stage writes take priority, queued auxiliary results drain in idle slots or by force.
// Optional macro GRF_WB_ARB_STATS_EN adds force_cnt_o, a saturating count of forced-write cycles.
module grf_wb_arbiter
    import grf_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    grf_wb_arbiter_if.slave bus
`ifdef GRF_WB_ARB_STATS_EN
    ,
    output logic [15:0]     force_cnt_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(STARVE_LIMIT + 1);

    state_t                      state_q, state_d;
    logic [AW-1:0]               age_q;
    logic                        pipe_busy, aux_ready, push, pop, stall;
    logic                        full, empty;
    logic [CW-1:0]               count;
    entry_t                      head;
    logic [DEPTH-1:0][REG_AW-1:0] addrs;
    logic [DEPTH-1:0]            valids;
    logic                        grf_we;
    logic [REG_AW-1:0]           grf_waddr;
    logic [DATA_W-1:0]           grf_wdata, grf_pc;
    logic                        pend1, pend2;

    assign pipe_busy = bus.pipe_we_i && (bus.pipe_waddr_i != '0);
    assign aux_ready = reset && !full;
    // Writes to r0 complete the handshake but are never queued.
    assign push      = bus.aux_valid_i && aux_ready && (bus.aux_waddr_i != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    ('{waddr: bus.aux_waddr_i, wdata: bus.aux_wdata_i, pc: bus.aux_pc_i}),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .addrs  (addrs),
        .valids (valids)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_q <= '0;
        end else if (pop || state_q == S_IDLE) begin
            age_q <= '0;
        end else if (state_q == S_WAIT && pipe_busy && age_q != AW'(STARVE_LIMIT)) begin
            age_q <= age_q + AW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        stall     = 1'b0;
        grf_we    = bus.pipe_we_i;
        grf_waddr = bus.pipe_waddr_i;
        grf_wdata = bus.pipe_wdata_i;
        grf_pc    = bus.pipe_pc_i;
        case (state_q)
            S_IDLE:  if (push) state_d = S_WAIT;
            S_WAIT: begin
                if (!pipe_busy && !empty) pop = 1'b1;
                else if (pipe_busy && age_q == AW'(STARVE_LIMIT - 1)) state_d = S_FORCE;
            end
            S_FORCE: begin
                pop   = 1'b1;
                stall = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            grf_we    = 1'b1;
            grf_waddr = head.waddr;
            grf_wdata = head.wdata;
            grf_pc    = head.pc;
            state_d   = (count == CW'(1) && !push) ? S_IDLE : S_WAIT;
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valids[i] && addrs[i] == bus.rd_addr1_i) pend1 = 1'b1;
            if (valids[i] && addrs[i] == bus.rd_addr2_i) pend2 = 1'b1;
        end
    end

    // Outputs are held at zero for as long as reset is asserted.
    assign bus.aux_ready_o  = aux_ready;
    assign bus.pipe_stall_o = reset && stall;
    assign bus.grf_we_o     = reset && grf_we;
    assign bus.grf_waddr_o  = reset ? grf_waddr : '0;
    assign bus.grf_wdata_o  = reset ? grf_wdata : '0;
    assign bus.grf_pc_o     = reset ? grf_pc    : '0;
    assign bus.rd_pend1_o   = reset && pend1 && (bus.rd_addr1_i != '0);
    assign bus.rd_pend2_o   = reset && pend2 && (bus.rd_addr2_i != '0);

`ifdef GRF_WB_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            force_cnt_o <= '0;
        end else if (state_q == S_FORCE && force_cnt_o != 16'hFFFF) begin
            force_cnt_o <= force_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scenario bench for grf_wb_arbiter: auxiliary writes are scoreboarded, pipeline writes checked against drive.
module tb_grf_wb_arbiter;
    import grf_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    grf_wb_arbiter_if bus ();
`ifdef GRF_WB_ARB_STATS_EN
    logic [15:0] force_cnt;
`endif

    grf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef GRF_WB_ARB_STATS_EN
        ,
        .force_cnt_o (force_cnt)
`endif
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    entry_t      exp_q[$];
    entry_t      e;
    entry_t      got;

    task automatic drive_pipe(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.pipe_we_i = we; bus.pipe_waddr_i = a; bus.pipe_wdata_i = d; bus.pipe_pc_i = pc;
    endtask

    task automatic drive_aux(input logic v, input entry_t x);
        bus.aux_valid_i = v; bus.aux_waddr_i = x.waddr; bus.aux_wdata_i = x.wdata; bus.aux_pc_i = x.pc;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive_pipe(1'b1, 5'd7, 32'hFFFF_0000, 32'h40);
        drive_aux(1'b1, '{5'd9, 32'h55, 32'h44});
        bus.rd_addr1_i = 5'd7; bus.rd_addr2_i = 5'd9;
        #12;
        checks++;
        if ({bus.grf_we_o, bus.grf_waddr_o, bus.grf_wdata_o, bus.grf_pc_o} !== 70'd0) begin
            errors++; $display("FAIL reset_grf: got we=%b a=%0d d=%h pc=%h, required all 0",
                               bus.grf_we_o, bus.grf_waddr_o, bus.grf_wdata_o, bus.grf_pc_o);
        end
        checks++;
        if ({bus.aux_ready_o, bus.pipe_stall_o, bus.rd_pend1_o, bus.rd_pend2_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl: got rdy/stall/p1/p2=%b%b%b%b, required 0000",
                               bus.aux_ready_o, bus.pipe_stall_o, bus.rd_pend1_o, bus.rd_pend2_o);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        drive_pipe(1'b0, '0, '0, '0);
        drive_aux(1'b0, '0);
        @(negedge clk);
        checks++;
        if (bus.aux_ready_o !== 1'b1 || bus.grf_we_o !== 1'b0) begin
            errors++; $display("FAIL reset_release: got ready=%b we=%b, required ready=1 we=0",
                               bus.aux_ready_o, bus.grf_we_o);
        end
`ifdef GRF_WB_ARB_STATS_EN
        checks++;
        if (force_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_force_cnt: got %0d, required 0", force_cnt);
        end
`endif
        next_cycle();
    endtask

    task automatic test_basic;
        drive_aux(1'b1, '{5'd8, 32'h1234, 32'h100});
        bus.rd_addr1_i = 5'd8; bus.rd_addr2_i = 5'd0;
        exp_q.push_back('{5'd8, 32'h1234, 32'h100});
        @(negedge clk);
        checks++;
        if (bus.aux_ready_o !== 1'b1 || bus.grf_we_o !== 1'b0 || bus.rd_pend1_o !== 1'b0) begin
            errors++; $display("FAIL basic_push: got ready=%b we=%b pend1=%b, required 1 0 0",
                               bus.aux_ready_o, bus.grf_we_o, bus.rd_pend1_o);
        end
        next_cycle();
        drive_aux(1'b0, '0);
        @(negedge clk);
        checks++;
        if (bus.grf_we_o !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL basic_we: got we=%b, required 1", bus.grf_we_o);
        end else begin
            e = exp_q.pop_front();
            got = '{bus.grf_waddr_o, bus.grf_wdata_o, bus.grf_pc_o};
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL basic_data: got %h, required %h", got, e);
            end
        end
        checks++;
        if (bus.rd_pend1_o !== 1'b1) begin
            errors++; $display("FAIL basic_pend_hi: got %b, required 1", bus.rd_pend1_o);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.grf_we_o !== 1'b0 || bus.rd_pend1_o !== 1'b0) begin
            errors++; $display("FAIL basic_after: got we=%b pend1=%b, required 0 0", bus.grf_we_o, bus.rd_pend1_o);
        end
        next_cycle();
    endtask

    task automatic test_starvation;
        int unsigned k = 0;
        logic exp_stall;
        bus.rd_addr1_i = 5'd3;
        for (int unsigned c = 0; c < 8; c++) begin
            drive_pipe(1'b1, 5'd5, 32'hC000 + k, 32'h1000 + 4 * k);
            if (c == 0) begin
                drive_aux(1'b1, '{5'd3, 32'hA5A5_0003, 32'h200});
                exp_q.push_back('{5'd3, 32'hA5A5_0003, 32'h200});
            end else begin
                drive_aux(1'b0, '0);
            end
            exp_stall = (c == 5);
            @(negedge clk);
            checks++;
            if (bus.pipe_stall_o !== exp_stall) begin
                errors++; $display("FAIL starve_stall c%0d: got %b, required %b", c, bus.pipe_stall_o, exp_stall);
            end
            if (exp_stall) begin
                e = exp_q.pop_front();
            end else begin
                e = '{5'd5, 32'hC000 + k, 32'h1000 + 4 * k};
            end
            got = '{bus.grf_waddr_o, bus.grf_wdata_o, bus.grf_pc_o};
            checks++;
            if (bus.grf_we_o !== 1'b1 || got !== e) begin
                errors++; $display("FAIL starve_write c%0d: got we=%b %h, required we=1 %h", c, bus.grf_we_o, got, e);
            end
            checks++;
            if (bus.rd_pend1_o !== (c >= 1 && c <= 5)) begin
                errors++; $display("FAIL starve_pend c%0d: got %b, required %b", c, bus.rd_pend1_o, (c >= 1 && c <= 5));
            end
            if (!exp_stall) k++;
            next_cycle();
        end
        drive_pipe(1'b0, '0, '0, '0);
        bus.rd_addr1_i = 5'd0;
`ifdef GRF_WB_ARB_STATS_EN
        checks++;
        if (force_cnt !== 16'd1) begin
            errors++; $display("FAIL force_cnt: got %0d, required 1", force_cnt);
        end
`endif
    endtask

    task automatic test_full_drain;
        logic [1:0] kind;  // 0 none, 1 pipeline, 2 auxiliary
        logic       exp_rdy, exp_p2;
        entry_t     ent [3];
        ent[0] = '{5'd10, 32'hE000_0000, 32'h500};
        ent[1] = '{5'd11, 32'hE000_0001, 32'h504};
        ent[2] = '{5'd12, 32'hE000_0002, 32'h508};
        bus.rd_addr1_i = 5'd0; bus.rd_addr2_i = 5'd11;
        for (int unsigned c = 0; c < 7; c++) begin
            drive_pipe(c < 3, 5'd5, 32'hD000 + c, 32'h3000 + 4 * c);
            if (c <= 1)      drive_aux(1'b1, ent[c]);
            else if (c <= 4) drive_aux(1'b1, ent[2]);
            else             drive_aux(1'b0, '0);
            if (c <= 1) exp_q.push_back(ent[c]);
            if (c == 4) exp_q.push_back(ent[2]);
            kind    = (c < 3) ? 2'd1 : (c < 6) ? 2'd2 : 2'd0;
            exp_rdy = !(c == 2 || c == 3);
            exp_p2  = (c >= 2 && c <= 4);
            @(negedge clk);
            checks++;
            if (bus.aux_ready_o !== exp_rdy) begin
                errors++; $display("FAIL full_ready c%0d: got %b, required %b", c, bus.aux_ready_o, exp_rdy);
            end
            checks++;
            if (bus.rd_pend2_o !== exp_p2 || bus.pipe_stall_o !== 1'b0) begin
                errors++; $display("FAIL full_pend c%0d: got pend2=%b stall=%b, required %b 0",
                                   c, bus.rd_pend2_o, bus.pipe_stall_o, exp_p2);
            end
            got = '{bus.grf_waddr_o, bus.grf_wdata_o, bus.grf_pc_o};
            checks++;
            if (kind == 2'd0) begin
                if (bus.grf_we_o !== 1'b0) begin
                    errors++; $display("FAIL full_idle c%0d: got we=%b, required 0", c, bus.grf_we_o);
                end
            end else begin
                if (kind == 2'd2) e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                else              e = '{5'd5, 32'hD000 + c, 32'h3000 + 4 * c};
                if (bus.grf_we_o !== 1'b1 || got !== e) begin
                    errors++; $display("FAIL full_write c%0d: got we=%b %h, required we=1 %h", c, bus.grf_we_o, got, e);
                end
            end
            next_cycle();
        end
        bus.rd_addr2_i = 5'd0;
    endtask

    task automatic test_zero_addr;
        drive_aux(1'b1, '{5'd0, 32'hDEAD, 32'h600});
        bus.rd_addr1_i = 5'd0;
        @(negedge clk);
        checks++;
        if (bus.aux_ready_o !== 1'b1) begin
            errors++; $display("FAIL zero_ready: got %b, required 1", bus.aux_ready_o);
        end
        next_cycle();
        drive_aux(1'b0, '0);
        for (int unsigned c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.grf_we_o !== 1'b0 || bus.rd_pend1_o !== 1'b0 || bus.pipe_stall_o !== 1'b0) begin
                errors++; $display("FAIL zero_nowrite c%0d: got we=%b pend1=%b stall=%b, required 0 0 0",
                                   c, bus.grf_we_o, bus.rd_pend1_o, bus.pipe_stall_o);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_drain;
        entry_t e0, e1;
        e0 = '{5'd20, 32'hF000_0020, 32'h700};
        e1 = '{5'd21, 32'hF000_0021, 32'h704};
        drive_pipe(1'b1, 5'd5, 32'h9000, 32'h4000);
        drive_aux(1'b1, e0); exp_q.push_back(e0);
        next_cycle();
        drive_aux(1'b1, e1); exp_q.push_back(e1);
        next_cycle();
        drive_pipe(1'b0, '0, '0, '0);
        drive_aux(1'b0, '0);
        bus.rd_addr1_i = 5'd21; bus.rd_addr2_i = 5'd20;
        @(negedge clk);
        got = '{bus.grf_waddr_o, bus.grf_wdata_o, bus.grf_pc_o};
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        if (bus.grf_we_o !== 1'b1 || got !== e || bus.rd_pend1_o !== 1'b1) begin
            errors++; $display("FAIL mid_first_pop: got we=%b %h pend1=%b, required we=1 %h pend1=1",
                               bus.grf_we_o, got, bus.rd_pend1_o, e);
        end
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({bus.grf_we_o, bus.pipe_stall_o, bus.aux_ready_o, bus.rd_pend1_o, bus.rd_pend2_o} !== 5'b0
            || {bus.grf_waddr_o, bus.grf_wdata_o, bus.grf_pc_o} !== 69'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got we=%b stall=%b rdy=%b p1=%b p2=%b a=%0d, required all 0",
                               bus.grf_we_o, bus.pipe_stall_o, bus.aux_ready_o, bus.rd_pend1_o,
                               bus.rd_pend2_o, bus.grf_waddr_o);
        end
        next_cycle();
        reset = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.grf_we_o !== 1'b0 || bus.rd_pend1_o !== 1'b0 || bus.aux_ready_o !== 1'b1) begin
                errors++; $display("FAIL mid_after c%0d: got we=%b pend1=%b ready=%b, required 0 0 1",
                                   c, bus.grf_we_o, bus.rd_pend1_o, bus.aux_ready_o);
            end
            next_cycle();
        end
        bus.rd_addr1_i = 5'd0; bus.rd_addr2_i = 5'd0;
`ifdef GRF_WB_ARB_STATS_EN
        checks++;
        if (force_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_force_cnt: got %0d, required 0", force_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_starvation();
        test_full_drain();
        test_zero_addr();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
Shares the single GRF write port between the W-stage pipeline write and a long-latency auxiliary producer, such as the multiply/divide unit result return.
- Auxiliary results are buffered in a small FIFO.
- The FIFO drains in cycles where the pipeline does not write the GRF.
- If an entry is starved, the block freezes the pipeline for one cycle to force the write.
- It also reports pending auxiliary writes against the current read addresses so the hazard unit can stall dependent instructions.

Parameters:
DEPTH, 2, auxiliary FIFO entries (power of two, ≥2)
STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before a forced write (≥1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pipe_we_i  in  1  W-stage write enable
pipe_waddr_i  in  5  W-stage destination register
pipe_wdata_i  in  32  W-stage write data
pipe_pc_i  in  32  W-stage PC, for the GRF trace
aux_valid_i  in  1  auxiliary write request
aux_ready_o  out  1  FIFO can accept; transfer occurs when valid&&ready
aux_waddr_i  in  5  auxiliary destination register
aux_wdata_i  in  32  auxiliary data
aux_pc_i  in  32  PC of the producing instruction
rd_addr1_i  in  5  current read address 1
rd_addr2_i  in  5  current read address 2
rd_pend1_o  out  1  rd_addr1_i (nonzero) matches a queued entry
rd_pend2_o  out  1  rd_addr2_i (nonzero) matches a queued entry
pipe_stall_o  out  1  freeze the pipeline this cycle (forced drain)
grf_we_o  out  1  GRF write enable
grf_waddr_o  out  5  GRF write address
grf_wdata_o  out  32  GRF write data
grf_pc_o  out  32  PC passed to the GRF

Behaviour:
- Port busy: pipe_busy = pipe_we_i && pipe_waddr_i!=0.
- Reset (reset=0, asynchronous):
  - FIFO emptied, age counter=0, state=S_IDLE.
  - All outputs 0, except aux_ready_o=1 once reset deasserts.
  - Queued entries are discarded, including on reset mid-operation.
- States:
  - S_IDLE: FIFO empty.
  - S_WAIT: FIFO non-empty, head waiting.
  - S_FORCE: head age reached STARVE_LIMIT.
- Age counter:
  - Cleared on every pop and in S_IDLE.
  - Increments each S_WAIT cycle with pipe_busy.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - S_IDLE→S_WAIT on push.
  - S_WAIT→S_FORCE when age==STARVE_LIMIT-1 and pipe_busy.
  - S_WAIT pop with FIFO not emptying stays in S_WAIT (age=0).
  - Any pop that empties the FIFO→S_IDLE.
  - S_FORCE always pops next, then goes to S_WAIT or S_IDLE.
- Port mux (combinational):
  - S_FORCE: grf_* = FIFO head, pipe_stall_o=1. The pipeline must hold its W-stage write and re-present it next cycle.
  - S_WAIT && !pipe_busy: grf_* = FIFO head; pop.
  - Otherwise: grf_* = pipe_*, with grf_we_o=pipe_we_i.
  - pipe_stall_o=0 in all states other than S_FORCE.
- Latency:
  - Pushed entry is written no earlier than the cycle after acceptance; there is no same-cycle bypass.
  - Worst case is STARVE_LIMIT+1 cycles after reaching the head.
- Full:
  - aux_ready_o=0 when count==DEPTH, even if a pop occurs the same cycle.
  - Push and pop in the same cycle when not full: count unchanged.
- aux_waddr_i==0: handshake completes, nothing enqueued, no pending flag.
- Pending flags:
  - OR of address matches over all valid FIFO entries, combinational.
  - Read address 0 never pending.
  - An entry being popped this cycle still reports pending.
- Ordering: the hazard unit uses rd_pend*_o to prevent a younger pipeline write to the same register overtaking a queued auxiliary write. The arbiter does not reorder.

Optional Feature:
Macro GRF_WB_ARB_STATS_EN.
- Defined: adds output port force_cnt_o (16 bits), a saturating count of S_FORCE cycles. It is cleared by reset and holds at 0xFFFF.
- Undefined: port absent, no counter logic; all other behaviour identical.

Decomposition:
- Package grf_arb_pkg:
  - state enum (S_IDLE, S_WAIT, S_FORCE)
  - REG_AW=5, DATA_W=32
  - entry struct {waddr, wdata, pc}
- Sub-module wb_fifo:
  - DEPTH-entry synchronous FIFO with push/pop/full/empty/count.
  - Flat visibility of entry addresses and valid bits for the pending compare.

Test Plan:
- Pipeline idle; aux push waddr=8, data=0x1234 at cycle t → grf_we_o=1, waddr=8, data=0x1234 at t+1; rd_pend for addr 8 high only during t+1.
- Pipeline writes every cycle, STARVE_LIMIT=4; push aux waddr=3 → pipe_stall_o=1 exactly once, in the 5th cycle after the push, with grf_waddr_o=3; pipeline write re-presented next cycle and written.
- Push 2 entries with pipeline busy → aux_ready_o=0 while full. Pipeline goes idle → entries drain in order on consecutive cycles; aux_ready_o=1 after the first pop.
- Aux push with waddr=0 → accepted, no GRF write, rd_pend1_o stays 0 with rd_addr1_i=0.
- Assert reset low mid-drain with 2 entries queued → outputs 0 immediately; after release FIFO is empty and there are no writes.
- With GRF_WB_ARB_STATS_EN defined → force_cnt_o=1 after the starvation scenario.
